apb_req_master: RTL and testbench

- Initiator end of the peripheral APB bus.
- Converts a core-side req/gnt/rvalid data request into one APB3 transfer (SETUP, then ACCESS).
- Drives the slave port of the peripheral bus node and returns read data and error status to the requester.
- One outstanding transfer at a time.

---
 rtl/apb_req_master.sv | 147 ++++++++++++++
 tb/tb_apb_req_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// APB3 initiator: turns one core-side req/gnt/rvalid request into a SETUP+ACCESS transfer.
// Optional access timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Reject unsupported configurations at elaboration time.
  if (APB_DATA_WIDTH != 32) begin : g_bad_width
    $error("apb_req_master: APB_DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_req_master: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt_o   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = we_i;
          // Misaligned requests are answered directly, no bus cycle.
          if (addr_i[1:0] != 2'b00) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
`ifdef APB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rdata_d = we_q ? '0 : prdata_i;
          err_d   = pslverr_i;
          state_d = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Bus strobes decode straight from state so reset drops them without a clock edge.
  assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o = (state_q == ACCESS);
  assign rvalid_o  = (state_q == RESP);
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;
  assign pwrite_o  = we_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Randomized self-checking bench for apb_req_master; expected timing and response
// come from a per-transfer model of the request/response protocol.
module tb_apb_req_master;

  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_checks = 0;
  int n_errors = 0;

  apb_req_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One transfer: request, then cycle-by-cycle expectations from the model.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int waits, input logic slverr, input logic [31:0] rdat,
                         input logic hold);
    bit          mis, timed_out;
    int          n_access;
    logic        exp_err;
    logic [31:0] exp_rdata;
    mis       = (addr[1:0] != 2'b00);
    timed_out = !mis && TO_EN && (waits >= TO);
    n_access  = timed_out ? TO : waits + 1;
    exp_err   = mis || timed_out || slverr;
    exp_rdata = (mis || timed_out || we) ? 32'h0 : rdat;

    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = addr; we_i = we; wdata_i = wdata;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
    @(negedge clk_i);
    check_val("gnt_idle", gnt_o, 1);
    check_val("psel_idle", psel_o, 0);
    @(posedge clk_i); #1;
    if (!hold) begin
      req_i = 1'b0; addr_i = $urandom; we_i = ~we; wdata_i = $urandom;
    end
    if (!mis) begin
      @(negedge clk_i);
      check_val("setup_psel", {psel_o, penable_o}, 2'b10);
      check_val("setup_paddr", paddr_o, addr);
      check_val("setup_pwrite", pwrite_o, we);
      check_val("setup_pwdata", pwdata_o, wdata);
      check_val("setup_rvalid", {rvalid_o, gnt_o}, 2'b00);
      for (int k = 0; k < n_access; k++) begin
        @(posedge clk_i); #1;
        pready_i  = (k == waits);
        pslverr_i = (k == waits) ? slverr : 1'($urandom);
        prdata_i  = (k == waits) ? rdat : $urandom;
        @(negedge clk_i);
        check_val("access_psel", {psel_o, penable_o}, 2'b11);
        check_val("access_addr", {pwrite_o, paddr_o}, {we, addr});
        check_val("access_pwdata", pwdata_o, wdata);
        check_val("access_rvalid", {rvalid_o, gnt_o}, 2'b00);
      end
      @(posedge clk_i); #1;
      pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
    end
    @(negedge clk_i);
    check_val("resp_rvalid", rvalid_o, 1);
    check_val("resp_err", err_o, exp_err);
    check_val("resp_rdata", rdata_o, exp_rdata);
    check_val("resp_bus", {psel_o, penable_o, gnt_o}, 3'b000);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    check_val("idle_rvalid", {rvalid_o, psel_o}, 2'b00);
    check_val("hold_rdata", {err_o, rdata_o}, {exp_err, exp_rdata});
    $display("txn addr=0x%08h we=%0d waits=%0d hold=%0d -> err=%0d rdata=0x%08h",
             addr, we, waits, hold, err_o, rdata_o);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_outputs", {rvalid_o, err_o, psel_o, penable_o, pwrite_o, gnt_o}, 6'b0);
    check_val("rst_data", {rdata_o, paddr_o, pwdata_o}, 96'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Directed cases from the test plan.
    run_txn(32'h1A10_0004, 1'b0, 32'h0,          0, 1'b0, 32'hCAFE_0001, 1'b0);
    run_txn(32'h1A10_1008, 1'b1, 32'h0000_00FF,  3, 1'b0, 32'h1234_5678, 1'b0);
    run_txn(32'h1A10_0010, 1'b0, 32'h0,          0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h1A10_0002, 1'b0, 32'h5555_AAAA,  0, 1'b0, 32'h0,         1'b0);
    run_txn(32'h1A10_0020, 1'b0, 32'h0,          6, 1'b0, 32'hA5A5_0000, 1'b1);
    run_txn(32'h1A10_0024, 1'b0, 32'h0,          3, 1'b0, 32'h0F0F_1111, 1'b0);

    // Reset in the middle of ACCESS: strobes drop immediately and no response follows.
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_0100; we_i = 1'b1; wdata_i = 32'hFEED_0001;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_val("pre_rst_access", {psel_o, penable_o}, 2'b11);
    #1 rst_i = 1'b1;
    #1;
    check_val("async_rst_bus", {psel_o, penable_o, rvalid_o, pwrite_o}, 4'b0000);
    check_val("async_rst_paddr", paddr_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val("post_rst_quiet", {rvalid_o, psel_o}, 2'b00);
    end
    run_txn(32'h1A10_0200, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom;
      a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(a, 1'($urandom), $urandom, $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0),
              $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
